// File: rtl/m_fetch_prefetch_buf_pkg.sv
// Shared fetch front-end definitions: data width, NOP encoding, FIFO entry layout.
package m_fetch_prefetch_buf_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/m_fetch_prefetch_buf_fifo.sv
// Prefetch FIFO: DEPTH-entry circular buffer of {pc, ir} with flush and occupancy count.
module m_fetch_fifo
  import m_fetch_prefetch_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [ENTRY_W-1:0]         data_i,
  output logic [ENTRY_W-1:0]         head_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic           full;
  logic           do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wr_ptr_q[AW-1:0]] <= fetch_entry_t'(data_i);
  end

  // A push into a full buffer is only safe when the head leaves in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) assert (!full || do_pop);
  end
endmodule

// File: rtl/m_fetch_prefetch_buf.sv
// Instruction-fetch front end: sequential fetch to a 1-cycle imem, prefetch FIFO to decode.
module m_fetch_prefetch_buf
  import m_fetch_prefetch_buf_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP      = NOP_INSN
) (
  input  logic        w_clock,
  input  logic        w_reset,
  output logic        w_imem_req,
  output logic [31:0] w_imem_addr,
  input  logic [31:0] w_imem_rdata,
  input  logic        w_redirect,
  input  logic [31:0] w_redirect_pc,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_ir,
  output logic [31:0] w_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W  = DEPTH[AW+1:0];
  localparam logic [31:0]   PC_RESET = {RESET_PC[31:2], 2'b00};

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  issued_pc_q, issued_pc_d;
  logic         inflight_q, inflight_d;
  logic [AW:0]  count;
  logic [AW+1:0] occ;
  logic         empty;
  logic         push, pop;
  logic [ENTRY_W-1:0] head_raw;
  fetch_entry_t head;
  logic         unused_rpc_lsb;

  assign unused_rpc_lsb = ^w_redirect_pc[1:0];

  // Credit: queued entries plus the response still in flight must leave room.
  assign occ        = {1'b0, count} + (AW+2)'(inflight_q);
  assign w_imem_req = !w_reset && !w_redirect && (occ < DEPTH_W);
  assign w_imem_addr = fetch_pc_q;

  assign push = inflight_q && !w_redirect;
  assign pop  = w_valid && w_ready && !w_redirect;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = inflight_q;
    if (w_redirect) begin
      fetch_pc_d = {w_redirect_pc[31:2], 2'b00};
      inflight_d = 1'b0;
    end else begin
      inflight_d = w_imem_req;
      if (w_imem_req) begin
        fetch_pc_d  = fetch_pc_q + 32'd4;
        issued_pc_d = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      fetch_pc_q  <= PC_RESET;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
    end
  end

  m_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (w_clock),
    .rst_i   (w_reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (w_redirect),
    .data_i  ({issued_pc_q, w_imem_rdata}),
    .head_o  (head_raw),
    .empty_o (empty),
    .count_o (count)
  );

  assign head    = fetch_entry_t'(head_raw);
  assign w_valid = !w_reset && !empty;
  assign w_ir    = w_valid ? head.ir : NOP;
  assign w_pc    = w_valid ? head.pc : 32'h0;
endmodule
